// File: rtl/jtcop_mcu_mbox_pkg.sv
// jtcop_mcu_mbox_pkg: strobe bit indices and channel-index width helper for the MCU mailbox
package jtcop_mcu_mbox_pkg;
  localparam int RD_HI = 0;
  localparam int RD_LO = 1;
  localparam int WR_LO = 2;
  localparam int WR_HI = 3;
  localparam int NSTB = 4;
  function automatic int chw(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/jtcop_mcu_mbox_if.sv
// jtcop_mcu_mbox_if: main-CPU and MCU side signals of the mailbox
interface jtcop_mcu_mbox_if import jtcop_mcu_mbox_pkg::*; #(parameter int NCH = 2);
  localparam int CHW = chw(NCH);
  logic [NCH-1:0] cpu_sel;
  logic           cpu_rnw;
  logic [1:0]     cpu_dsn;
  logic [15:0]    cpu_dout;
  logic [15:0]    cpu_din;
  logic           cpu_irqn;
  logic [CHW-1:0] mcu_ch;
  logic [7:0]     mcu_p0o;
  logic [7:0]     mcu_p0i;
  logic           mcu_rd_hi;
  logic           mcu_rd_lo;
  logic           mcu_wr_lo;
  logic           mcu_wr_hi;
  logic           mcu_int_en;
  logic           mcu_intn;
  logic [NCH-1:0] pending;
  modport master(
    output cpu_sel, cpu_rnw, cpu_dsn, cpu_dout, mcu_ch, mcu_p0o,
           mcu_rd_hi, mcu_rd_lo, mcu_wr_lo, mcu_wr_hi, mcu_int_en,
    input  cpu_din, cpu_irqn, mcu_p0i, mcu_intn, pending
  );
  modport slave(
    input  cpu_sel, cpu_rnw, cpu_dsn, cpu_dout, mcu_ch, mcu_p0o,
           mcu_rd_hi, mcu_rd_lo, mcu_wr_lo, mcu_wr_hi, mcu_int_en,
    output cpu_din, cpu_irqn, mcu_p0i, mcu_intn, pending
  );
endinterface

// File: rtl/jtcop_mcu_mbox_edge.sv
// jtcop_mcu_mbox_edge: rising-edge detector whose history follows the input through reset, so held lines stay silent
module jtcop_mcu_mbox_edge #(parameter int W = 1) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] ev
);
  logic [W-1:0] q;
  always_ff @(posedge clk) q <= d;
  assign ev = d & ~q & {W{~rst}};
endmodule

// File: rtl/jtcop_mcu_mbox.sv
// jtcop_mcu_mbox: multi-channel 16-bit mailbox between the 68000 main CPU and the i8751 MCU
module jtcop_mcu_mbox import jtcop_mcu_mbox_pkg::*; #(
  parameter int NCH       = 2,
  parameter int IRQ_MODE  = 0,
  parameter int IRQ_CH    = 0,
  parameter int CLR_ON_LO = 1
) (
  input logic             clk,
  input logic             rst,
  jtcop_mcu_mbox_if.slave bus
);
  localparam int CHW = chw(NCH);
  logic [NCH-1:0]       sel_ev, pend, pend_nx;
  logic [NSTB-1:0]      stb, stb_ev;
  logic [NCH-1:0][15:0] tx, tx_nx, rx, rx_nx;
  logic [15:0]          din, din_nx;
  logic [7:0]           p0i, p0i_nx;
  logic                 intl, int_nx, irqn, irqn_nx, clr, cpu_wr;
  assign stb[RD_HI] = bus.mcu_rd_hi;
  assign stb[RD_LO] = bus.mcu_rd_lo;
  assign stb[WR_LO] = bus.mcu_wr_lo;
  assign stb[WR_HI] = bus.mcu_wr_hi;
  jtcop_mcu_mbox_edge #(.W(NCH))  u_sel (.clk(clk), .rst(rst), .d(bus.cpu_sel), .ev(sel_ev));
  jtcop_mcu_mbox_edge #(.W(NSTB)) u_stb (.clk(clk), .rst(rst), .d(stb), .ev(stb_ev));
  assign clr    = CLR_ON_LO != 0 ? stb_ev[RD_LO] : stb_ev[RD_HI];
  assign cpu_wr = |sel_ev & ~bus.cpu_rnw;
  // MCU side is applied before the CPU write so a same-cycle CPU write wins over the clearing read
  always_comb begin
    tx_nx   = tx;
    rx_nx   = rx;
    pend_nx = pend;
    din_nx  = din;
    p0i_nx  = stb_ev[RD_HI] | stb_ev[RD_LO] ? 8'hff : p0i;
    irqn_nx = sel_ev[IRQ_CH] & bus.cpu_rnw ? 1'b1 : irqn;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (bus.cpu_sel[k]) din_nx = rx[k];
      if (bus.mcu_ch == CHW'(k)) begin
        if (stb_ev[RD_LO]) p0i_nx = tx[k][7:0];
        else if (stb_ev[RD_HI]) p0i_nx = tx[k][15:8];
        if (clr) pend_nx[k] = 1'b0;
        if (stb_ev[WR_LO]) rx_nx[k][7:0] = bus.mcu_p0o;
        if (stb_ev[WR_HI]) rx_nx[k][15:8] = bus.mcu_p0o;
      end
      if (sel_ev[k] & ~bus.cpu_rnw) begin
        if (!bus.cpu_dsn[1]) tx_nx[k][15:8] = bus.cpu_dout[15:8];
        if (!bus.cpu_dsn[0]) tx_nx[k][7:0] = bus.cpu_dout[7:0];
        pend_nx[k] = 1'b1;
      end
    end
    if (IRQ_MODE != 0 && stb_ev[WR_HI] && bus.mcu_ch == CHW'(IRQ_CH)) irqn_nx = 1'b0;
    int_nx = (intl | cpu_wr) & bus.mcu_int_en & |pend_nx;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      tx   <= '0;
      rx   <= '0;
      pend <= '0;
      din  <= '0;
      p0i  <= '0;
      intl <= 1'b0;
      irqn <= 1'b1;
    end else begin
      tx   <= tx_nx;
      rx   <= rx_nx;
      pend <= pend_nx;
      din  <= din_nx;
      p0i  <= p0i_nx;
      intl <= int_nx;
      irqn <= irqn_nx;
    end
  end
  assign bus.cpu_din  = din;
  assign bus.mcu_p0i  = p0i;
  assign bus.pending  = pend;
  assign bus.cpu_irqn = irqn;
  assign bus.mcu_intn = ~(intl & bus.mcu_int_en);
endmodule

// File: tb/tb_jtcop_mcu_mbox.sv
// tb_jtcop_mcu_mbox: directed and randomized checks of the mailbox against a transaction-level model
module tb_jtcop_mcu_mbox;
  localparam int NCH = 3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  jtcop_mcu_mbox_if #(.NCH(NCH)) bus();
  jtcop_mcu_mbox #(.NCH(NCH), .IRQ_MODE(1), .IRQ_CH(0), .CLR_ON_LO(1)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  int errors = 0;
  int checks = 0;
  logic [15:0]    m_tx [NCH];
  logic [15:0]    m_rx [NCH];
  logic [NCH-1:0] m_pend;
  logic [15:0]    m_din;
  logic [7:0]     m_p0i;
  bit             m_int, m_irq, m_en;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_tx[i] = '0;
      m_rx[i] = '0;
    end
    m_pend = '0;
    m_din  = '0;
    m_p0i  = '0;
    m_int  = 1'b0;
    m_irq  = 1'b0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pending"}, 32'(bus.pending), 32'(m_pend));
    chk({tag, ".mcu_intn"}, 32'(bus.mcu_intn), 32'(!(m_int && m_en)));
    chk({tag, ".cpu_irqn"}, 32'(bus.cpu_irqn), 32'(!m_irq));
    chk({tag, ".cpu_din"}, 32'(bus.cpu_din), 32'(m_din));
    chk({tag, ".mcu_p0i"}, 32'(bus.mcu_p0i), 32'(m_p0i));
  endtask

  task automatic idle_inputs();
    bus.cpu_sel   = '0;
    bus.mcu_rd_hi = 1'b0;
    bus.mcu_rd_lo = 1'b0;
    bus.mcu_wr_lo = 1'b0;
    bus.mcu_wr_hi = 1'b0;
  endtask

  // one cycle of activity: cc<0 means no CPU access; mc may name a missing channel
  task automatic do_op(input string tag, input int cc, input bit rnw, input logic [15:0] d,
                       input logic [1:0] dsn, input int mc, input bit rh, input bit rl,
                       input bit wl, input bit wh, input logic [7:0] b);
    @(negedge clk);
    bus.cpu_sel = '0;
    if (cc >= 0) bus.cpu_sel[cc] = 1'b1;
    bus.cpu_rnw   = rnw;
    bus.cpu_dout  = d;
    bus.cpu_dsn   = dsn;
    bus.mcu_ch    = 2'(mc);
    bus.mcu_p0o   = b;
    bus.mcu_rd_hi = rh;
    bus.mcu_rd_lo = rl;
    bus.mcu_wr_lo = wl;
    bus.mcu_wr_hi = wh;
    @(negedge clk);
    idle_inputs();
    if (cc >= 0) m_din = m_rx[cc];
    if (cc == 0 && rnw) m_irq = 1'b0;
    if (rh || rl) begin
      if (mc < NCH) begin
        m_p0i = rl ? m_tx[mc][7:0] : m_tx[mc][15:8];
        if (rl) m_pend[mc] = 1'b0;
      end else m_p0i = 8'hff;
    end
    if (mc < NCH) begin
      if (wl) m_rx[mc][7:0] = b;
      if (wh) m_rx[mc][15:8] = b;
      if (wh && mc == 0) m_irq = 1'b1;
    end
    if (cc >= 0 && !rnw) begin
      if (!dsn[1]) m_tx[cc][15:8] = d[15:8];
      if (!dsn[0]) m_tx[cc][7:0] = d[7:0];
      m_pend[cc] = 1'b1;
      if (m_en) m_int = 1'b1;
    end
    m_int = m_int && m_en && (m_pend != 0);
    check_all(tag);
  endtask

  task automatic set_en(input bit e);
    @(negedge clk);
    bus.mcu_int_en = e;
    @(negedge clk);
    m_en  = e;
    m_int = m_int && m_en && (m_pend != 0);
    check_all("int_en");
  endtask

  initial begin
    idle_inputs();
    bus.cpu_rnw    = 1'b1;
    bus.cpu_dsn    = 2'b11;
    bus.cpu_dout   = '0;
    bus.mcu_ch     = '0;
    bus.mcu_p0o    = '0;
    bus.mcu_int_en = 1'b1;
    m_en = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst.cpu_din", 32'(bus.cpu_din), 32'h0);
    chk("rst.mcu_p0i", 32'(bus.mcu_p0i), 32'h0);
    chk("rst.mcu_intn", 32'(bus.mcu_intn), 32'h1);
    chk("rst.cpu_irqn", 32'(bus.cpu_irqn), 32'h1);
    chk("rst.pending", 32'(bus.pending), 32'h0);
    rst = 1'b0;
    do_op("t1.wr", 1, 1'b0, 16'h1234, 2'b00, 0, 0, 0, 0, 0, 8'h00);
    chk("t1.pending", 32'(bus.pending), 32'b010);
    chk("t1.intn", 32'(bus.mcu_intn), 32'h0);
    do_op("t1.rdhi", -1, 1'b1, 16'h0, 2'b11, 1, 1, 0, 0, 0, 8'h00);
    chk("t1.p0i_hi", 32'(bus.mcu_p0i), 32'h12);
    do_op("t1.rdlo", -1, 1'b1, 16'h0, 2'b11, 1, 0, 1, 0, 0, 8'h00);
    chk("t1.p0i_lo", 32'(bus.mcu_p0i), 32'h34);
    chk("t1.pending_clr", 32'(bus.pending), 32'h0);
    chk("t1.intn_rel", 32'(bus.mcu_intn), 32'h1);
    do_op("t2.wr", 0, 1'b0, 16'h1234, 2'b00, 0, 0, 0, 0, 0, 8'h00);
    do_op("t2.wrhi", 0, 1'b0, 16'hABCD, 2'b01, 0, 0, 0, 0, 0, 8'h00);
    do_op("t2.rdhi", -1, 1'b1, 16'h0, 2'b11, 0, 1, 0, 0, 0, 8'h00);
    chk("t2.hi", 32'(bus.mcu_p0i), 32'hAB);
    do_op("t2.rdlo", -1, 1'b1, 16'h0, 2'b11, 0, 0, 1, 0, 0, 8'h00);
    chk("t2.lo", 32'(bus.mcu_p0i), 32'h34);
    do_op("t2.nodsn", 0, 1'b0, 16'h5678, 2'b11, 0, 0, 0, 0, 0, 8'h00);
    chk("t2.nodsn_pend", 32'(bus.pending[0]), 32'h1);
    do_op("t2.kept", -1, 1'b1, 16'h0, 2'b11, 0, 0, 1, 0, 0, 8'h00);
    chk("t2.kept_lo", 32'(bus.mcu_p0i), 32'h34);
    do_op("t3.wrlo", -1, 1'b1, 16'h0, 2'b11, 0, 0, 0, 1, 0, 8'h55);
    do_op("t3.wrhi", -1, 1'b1, 16'h0, 2'b11, 0, 0, 0, 0, 1, 8'hAA);
    chk("t3.irqn_set", 32'(bus.cpu_irqn), 32'h0);
    do_op("t3.rd", 0, 1'b1, 16'h0, 2'b11, 0, 0, 0, 0, 0, 8'h00);
    chk("t3.din", 32'(bus.cpu_din), 32'hAA55);
    chk("t3.irqn_rel", 32'(bus.cpu_irqn), 32'h1);
    do_op("t4.race", 2, 1'b0, 16'hBEEF, 2'b00, 2, 0, 1, 0, 0, 8'h00);
    chk("t4.pend", 32'(bus.pending[2]), 32'h1);
    chk("t4.intn", 32'(bus.mcu_intn), 32'h0);
    do_op("t4.irqrace", 0, 1'b1, 16'h0, 2'b11, 0, 0, 0, 0, 1, 8'h77);
    chk("t4.irq_wins", 32'(bus.cpu_irqn), 32'h0);
    do_op("t4.drain", -1, 1'b1, 16'h0, 2'b11, 2, 1, 1, 0, 0, 8'h00);
    set_en(1'b0);
    do_op("t5.wr", 1, 1'b0, 16'h4321, 2'b00, 0, 0, 0, 0, 0, 8'h00);
    chk("t5.intn", 32'(bus.mcu_intn), 32'h1);
    chk("t5.pend", 32'(bus.pending[1]), 32'h1);
    set_en(1'b1);
    do_op("t5.bad", -1, 1'b1, 16'h0, 2'b11, 3, 1, 0, 1, 1, 8'h99);
    chk("t5.ff", 32'(bus.mcu_p0i), 32'hff);
    @(negedge clk);
    bus.cpu_rnw = 1'b1;
    bus.cpu_sel = 3'b110;
    @(negedge clk);
    idle_inputs();
    m_din = m_rx[1];
    check_all("multisel");
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 15) == 0) set_en(1'($urandom_range(0, 1)));
      else do_op("rnd", int'($urandom_range(0, 3)) - 1, 1'($urandom_range(0, 1)), 16'($urandom),
                 2'($urandom), int'($urandom_range(0, 3)), $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                 8'($urandom));
    end
    @(negedge clk);
    rst = 1'b1;
    bus.cpu_sel[1] = 1'b1;
    bus.cpu_rnw    = 1'b0;
    bus.cpu_dsn    = 2'b00;
    bus.mcu_ch     = 2'd0;
    bus.mcu_rd_lo  = 1'b1;
    bus.mcu_wr_hi  = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    model_reset();
    chk("t6.pending", 32'(bus.pending), 32'h0);
    chk("t6.intn", 32'(bus.mcu_intn), 32'(!m_en ? 1 : 1));
    chk("t6.irqn", 32'(bus.cpu_irqn), 32'h1);
    chk("t6.p0i", 32'(bus.mcu_p0i), 32'h0);
    chk("t6.din", 32'(bus.cpu_din), 32'h0);
    idle_inputs();
    @(negedge clk);
    check_all("t6.fall");
    do_op("t6.rise", 1, 1'b0, 16'hC0DE, 2'b00, 0, 0, 0, 0, 1, 8'h3C);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
